// File: rtl/gcbp_motion_search_pkg.sv
// Shared GCBP geometry, BRAM addressing and FSM encoding for the motion-search stage.
// Must stay consistent with the GCBP writer's view of the BRAM array.
package gcbp_motion_search_pkg;

   localparam int C_SUB_DIM      = 64;   // sub-image is 64x64 pixels
   localparam int C_GRID_DIM     = 4;    // 4x4 grid of sub-images
   localparam int C_NUM_SUB      = C_GRID_DIM * C_GRID_DIM;
   localparam int C_IDX_BITS     = 4;
   localparam int C_LOC_BITS     = 2;
   localparam int C_ROW_BITS     = 7;
   localparam int C_ROW_IDX_BITS = 6;
   localparam int C_ADDR_BITS    = C_LOC_BITS + C_ROW_BITS;
   localparam int C_DATA_BITS    = 128;
   localparam int C_WIN_LO       = 32;
   localparam int C_WIN_HI       = 95;
   localparam int C_WIN_BITS     = C_WIN_HI - C_WIN_LO + 1;
   localparam int C_PC_BITS      = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CUR,
      S_RD_PRV,
      S_ACC,
      S_CMP,
      S_EMIT,
      S_DONE
   } state_t;

   // Row field is 7 bits wide but rows only span 0..63, so bit 6 is tied low.
   function automatic logic [C_ADDR_BITS-1:0] bram_addr(input logic [C_LOC_BITS-1:0]     loc,
                                                        input logic [C_ROW_IDX_BITS-1:0] row);
      return {loc, 1'b0, row};
   endfunction

endpackage

// File: rtl/gcbp_popcnt64.sv
// Combinational population count of one 64-bit XOR window.
module gcbp_popcnt64
   import gcbp_motion_search_pkg::*;
(
   input  logic [C_WIN_BITS-1:0] i_data,
   output logic [C_PC_BITS-1:0]  o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < C_WIN_BITS; i++) begin
         o_count = o_count + C_PC_BITS'(i_data[i]);
      end
   end

endmodule

// File: rtl/gcbp_motion_search.sv
// Per-frame block-matching motion search over all 16 GCBP sub-images.
// XOR-popcount cost, all dx candidates of one dy pass accumulated in parallel.
module gcbp_motion_search
   import gcbp_motion_search_pkg::*;
#(
   parameter int C_SEARCH_RANGE = 4,
   parameter int C_OFS_BITS     = 4,
   parameter int C_COST_BITS    = 12
)(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [C_LOC_BITS-1:0]   i_curr_frame_loc,
   input  logic [C_LOC_BITS-1:0]   i_prev_frame_loc,
   output logic [C_IDX_BITS-1:0]   o_bram_rd_sel,
   output logic [C_ADDR_BITS-1:0]  o_bram_rd_addr,
   input  logic [C_DATA_BITS-1:0]  i_bram_rd_data,
   output logic                    o_busy,
   output logic                    o_result_valid,
   output logic [C_IDX_BITS-1:0]   o_result_idx,
   output logic [C_OFS_BITS-1:0]   o_result_dx,
   output logic [C_OFS_BITS-1:0]   o_result_dy,
   output logic [C_COST_BITS-1:0]  o_result_cost,
   output logic                    o_done,
   output logic                    o_overrun
);

   localparam int S     = C_SEARCH_RANGE;
   localparam int NCAND = 2 * S + 1;
   localparam int KW    = $clog2(NCAND);

   localparam logic [C_ROW_IDX_BITS-1:0] ROW_FIRST = C_ROW_IDX_BITS'(S);
   localparam logic [C_ROW_IDX_BITS-1:0] ROW_LAST  = C_ROW_IDX_BITS'(C_SUB_DIM - 1 - S);
   localparam logic [KW-1:0]             K_LAST    = KW'(NCAND - 1);
   localparam logic [KW-1:0]             K_CENTER  = KW'(S);
   localparam logic [C_IDX_BITS-1:0]     IDX_LAST  = C_IDX_BITS'(C_NUM_SUB - 1);

   state_t                                state_q, state_d;
   logic [C_IDX_BITS-1:0]                 idx_q, idx_d;
   logic [KW-1:0]                         dyk_q, dyk_d;
   logic [KW-1:0]                         k_q, k_d;
   logic [C_ROW_IDX_BITS-1:0]             row_q, row_d;
   logic [C_LOC_BITS-1:0]                 curr_loc_q, curr_loc_d;
   logic [C_LOC_BITS-1:0]                 prev_loc_q, prev_loc_d;
   logic [C_WIN_BITS-1:0]                 cur_win_q, cur_win_d;
   logic [NCAND-1:0][C_COST_BITS-1:0]     acc_q, acc_d;
   logic [C_COST_BITS-1:0]                best_cost_q, best_cost_d;
   logic [C_OFS_BITS-1:0]                 best_dx_q, best_dx_d;
   logic [C_OFS_BITS-1:0]                 best_dy_q, best_dy_d;
   logic [C_IDX_BITS-1:0]                 rd_sel_q, rd_sel_d;
   logic [C_ADDR_BITS-1:0]                rd_addr_q, rd_addr_d;
   logic                                  busy_q, busy_d;
   logic                                  res_valid_q, res_valid_d;
   logic [C_IDX_BITS-1:0]                 res_idx_q, res_idx_d;
   logic [C_OFS_BITS-1:0]                 res_dx_q, res_dx_d;
   logic [C_OFS_BITS-1:0]                 res_dy_q, res_dy_d;
   logic [C_COST_BITS-1:0]                res_cost_q, res_cost_d;
   logic                                  done_q, done_d;
   logic                                  overrun_q, overrun_d;

   logic [NCAND-1:0][C_PC_BITS-1:0]       pc;
   logic [C_COST_BITS-1:0]                cand_cost;
   logic                                  cand_take;
   logic                                  unused_data;

   // Candidate k compares the current window against prev shifted by dx = k - S.
   for (genvar g = 0; g < NCAND; g++) begin : g_cand
      gcbp_popcnt64 u_popcnt (
         .i_data  (cur_win_q ^ i_bram_rd_data[C_WIN_LO + g - S +: C_WIN_BITS]),
         .o_count (pc[g])
      );
   end

   assign unused_data = ^i_bram_rd_data;

   assign cand_cost = acc_q[k_q];
   assign cand_take = (cand_cost < best_cost_q) ||
                      ((cand_cost == best_cost_q) && (k_q == K_CENTER) && (dyk_q == K_CENTER));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dyk_d       = dyk_q;
      k_d         = k_q;
      row_d       = row_q;
      curr_loc_d  = curr_loc_q;
      prev_loc_d  = prev_loc_q;
      cur_win_d   = cur_win_q;
      acc_d       = acc_q;
      best_cost_d = best_cost_q;
      best_dx_d   = best_dx_q;
      best_dy_d   = best_dy_q;
      busy_d      = busy_q;
      res_valid_d = 1'b0;
      res_idx_d   = res_idx_q;
      res_dx_d    = res_dx_q;
      res_dy_d    = res_dy_q;
      res_cost_d  = res_cost_q;
      done_d      = 1'b0;
      overrun_d   = i_start && (state_q != S_IDLE);
      rd_sel_d    = '0;
      rd_addr_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d     = S_RD_CUR;
               curr_loc_d  = i_curr_frame_loc;
               prev_loc_d  = i_prev_frame_loc;
               idx_d       = '0;
               dyk_d       = '0;
               row_d       = ROW_FIRST;
               acc_d       = '0;
               best_cost_d = '1;
               best_dx_d   = '0;
               best_dy_d   = '0;
               busy_d      = 1'b1;
            end
         end
         S_RD_CUR: state_d = S_RD_PRV;
         S_RD_PRV: begin
            state_d   = S_ACC;
            cur_win_d = i_bram_rd_data[C_WIN_HI:C_WIN_LO];
         end
         S_ACC: begin
            for (int k = 0; k < NCAND; k++) begin
               acc_d[k] = acc_q[k] + C_COST_BITS'(pc[k]);
            end
            if (row_q == ROW_LAST) begin
               state_d = S_CMP;
               k_d     = '0;
            end else begin
               state_d = S_RD_CUR;
               row_d   = row_q + 1'b1;
            end
         end
         S_CMP: begin
            if (cand_take) begin
               best_cost_d = cand_cost;
               best_dx_d   = C_OFS_BITS'(int'(k_q) - S);
               best_dy_d   = C_OFS_BITS'(int'(dyk_q) - S);
            end
            if (k_q != K_LAST) begin
               k_d = k_q + 1'b1;
            end else if (dyk_q != K_LAST) begin
               state_d = S_RD_CUR;
               dyk_d   = dyk_q + 1'b1;
               row_d   = ROW_FIRST;
               acc_d   = '0;
            end else begin
               // Result takes the post-update best so the final candidate counts.
               state_d     = S_EMIT;
               res_valid_d = 1'b1;
               res_idx_d   = idx_q;
               res_dx_d    = best_dx_d;
               res_dy_d    = best_dy_d;
               res_cost_d  = best_cost_d;
            end
         end
         S_EMIT: begin
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d     = S_RD_CUR;
               idx_d       = idx_q + 1'b1;
               dyk_d       = '0;
               row_d       = ROW_FIRST;
               acc_d       = '0;
               best_cost_d = '1;
               best_dx_d   = '0;
               best_dy_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // Read port is registered: the address is set up on entry to each read state.
      if (state_d == S_RD_CUR) begin
         rd_sel_d  = idx_d;
         rd_addr_d = bram_addr(curr_loc_d, row_d);
      end else if (state_d == S_RD_PRV) begin
         rd_sel_d  = idx_d;
         rd_addr_d = bram_addr(prev_loc_d, row_d + C_ROW_IDX_BITS'(dyk_d) - C_ROW_IDX_BITS'(S));
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         dyk_q       <= '0;
         k_q         <= '0;
         row_q       <= '0;
         curr_loc_q  <= '0;
         prev_loc_q  <= '0;
         cur_win_q   <= '0;
         acc_q       <= '0;
         best_cost_q <= '0;
         best_dx_q   <= '0;
         best_dy_q   <= '0;
         rd_sel_q    <= '0;
         rd_addr_q   <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_dx_q    <= '0;
         res_dy_q    <= '0;
         res_cost_q  <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dyk_q       <= dyk_d;
         k_q         <= k_d;
         row_q       <= row_d;
         curr_loc_q  <= curr_loc_d;
         prev_loc_q  <= prev_loc_d;
         cur_win_q   <= cur_win_d;
         acc_q       <= acc_d;
         best_cost_q <= best_cost_d;
         best_dx_q   <= best_dx_d;
         best_dy_q   <= best_dy_d;
         rd_sel_q    <= rd_sel_d;
         rd_addr_q   <= rd_addr_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
         res_dx_q    <= res_dx_d;
         res_dy_q    <= res_dy_d;
         res_cost_q  <= res_cost_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_bram_rd_sel  = rd_sel_q;
   assign o_bram_rd_addr = rd_addr_q;
   assign o_busy         = busy_q;
   assign o_result_valid = res_valid_q;
   assign o_result_idx   = res_idx_q;
   assign o_result_dx    = res_dx_q;
   assign o_result_dy    = res_dy_q;
   assign o_result_cost  = res_cost_q;
   assign o_done         = done_q;
   assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_gcbp_motion_search.sv
// Scoreboard bench for gcbp_motion_search: directed frame contents with known best offsets,
// a behavioural 1-cycle-latency BRAM, and a forked monitor that checks each result pulse.
module tb_gcbp_motion_search;

   localparam int S       = 4;
   localparam int OFS     = 4;
   localparam int CB      = 12;
   localparam int LATENCY = 25505;

   typedef struct packed {
      logic [3:0]    idx;
      logic [OFS-1:0] dx;
      logic [OFS-1:0] dy;
      logic [CB-1:0]  cost;
   } res_t;

   logic           i_clk = 1'b0;
   logic           i_reset = 1'b1;
   logic           i_start = 1'b0;
   logic [1:0]     i_curr_frame_loc = '0;
   logic [1:0]     i_prev_frame_loc = '0;
   logic [3:0]     o_bram_rd_sel;
   logic [8:0]     o_bram_rd_addr;
   logic [127:0]   i_bram_rd_data = '0;
   logic           o_busy, o_result_valid, o_done, o_overrun;
   logic [3:0]     o_result_idx;
   logic [OFS-1:0] o_result_dx, o_result_dy;
   logic [CB-1:0]  o_result_cost;

   logic [127:0]   mem [0:4095];
   res_t           exp_q [$];
   int             checks = 0;
   int             errors = 0;

   gcbp_motion_search #(.C_SEARCH_RANGE(S), .C_OFS_BITS(OFS), .C_COST_BITS(CB)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_curr_frame_loc (i_curr_frame_loc),
      .i_prev_frame_loc (i_prev_frame_loc),
      .o_bram_rd_sel    (o_bram_rd_sel),
      .o_bram_rd_addr   (o_bram_rd_addr),
      .i_bram_rd_data   (i_bram_rd_data),
      .o_busy           (o_busy),
      .o_result_valid   (o_result_valid),
      .o_result_idx     (o_result_idx),
      .o_result_dx      (o_result_dx),
      .o_result_dy      (o_result_dy),
      .o_result_cost    (o_result_cost),
      .o_done           (o_done),
      .o_overrun        (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk)
      i_bram_rd_data <= mem[{o_bram_rd_sel, o_bram_rd_addr[8:7], o_bram_rd_addr[5:0]}];

   function automatic int maddr(input int sel, input int loc, input int row);
      return sel * 256 + loc * 64 + row;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic fill_equal(input int sel, input int cl, input int pl);
      logic [127:0] d;
      for (int r = 0; r < 64; r++) begin
         d = rnd128();
         mem[maddr(sel, cl, r)] = d;
         mem[maddr(sel, pl, r)] = d;
      end
   endtask

   task automatic fill_const(input int sel, input int cl, input int pl,
                             input logic [127:0] cv, input logic [127:0] pv);
      for (int r = 0; r < 64; r++) begin
         mem[maddr(sel, cl, r)] = cv;
         mem[maddr(sel, pl, r)] = pv;
      end
   endtask

   // prev row p holds curr row p+2 moved up 3 bit positions: best match is dx=+3, dy=-2.
   task automatic fill_shift(input int sel, input int cl, input int pl);
      logic [127:0] cur [64];
      for (int r = 0; r < 64; r++) begin
         cur[r] = rnd128();
         mem[maddr(sel, cl, r)] = cur[r];
      end
      for (int p = 0; p < 64; p++) begin
         if (p + 2 <= 63) mem[maddr(sel, pl, p)] = cur[p + 2] << 3;
         else             mem[maddr(sel, pl, p)] = rnd128();
      end
   endtask

   task automatic push_exp(input int idx, input logic [OFS-1:0] dx, input logic [OFS-1:0] dy,
                           input logic [CB-1:0] cost);
      res_t e;
      e.idx  = 4'(idx);
      e.dx   = dx;
      e.dy   = dy;
      e.cost = cost;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},    32'(o_busy), 32'd0);
      check({tag, "_valid"},   32'(o_result_valid), 32'd0);
      check({tag, "_done"},    32'(o_done), 32'd0);
      check({tag, "_overrun"}, 32'(o_overrun), 32'd0);
      check({tag, "_sel"},     32'(o_bram_rd_sel), 32'd0);
      check({tag, "_addr"},    32'(o_bram_rd_addr), 32'd0);
      check({tag, "_res"},     32'({o_result_idx, o_result_dx, o_result_dy, o_result_cost}), 32'd0);
   endtask

   task automatic start_sweep(input int cl, input int pl);
      @(posedge i_clk);
      #1;
      i_curr_frame_loc = 2'(cl);
      i_prev_frame_loc = 2'(pl);
      i_start = 1'b1;
   endtask

   // mode 1: overrun and input-change injection; mode 2: first read address checks.
   task automatic run_to_done(input int mode, input string tag);
      int n;
      n = 0;
      while (1) begin
         tick();
         n++;
         if (n == 1) i_start = 1'b0;
         if (mode == 2 && n == 1) begin
            check({tag, "_rd0_sel"},  32'(o_bram_rd_sel), 32'd0);
            check({tag, "_rd0_addr"}, 32'(o_bram_rd_addr), 32'h104);
         end
         if (mode == 2 && n == 2) begin
            check({tag, "_rd1_sel"},  32'(o_bram_rd_sel), 32'd0);
            check({tag, "_rd1_addr"}, 32'(o_bram_rd_addr), 32'h080);
         end
         if (n == 50) check({tag, "_busy_mid"}, 32'(o_busy), 32'd1);
         if (mode == 1 && n == 100) begin
            i_start = 1'b1;
            i_curr_frame_loc = 2'd1;
            i_prev_frame_loc = 2'd2;
         end
         if (mode == 1 && n == 101) begin
            check({tag, "_overrun"}, 32'(o_overrun), 32'd1);
            i_start = 1'b0;
         end
         if (o_done) break;
         if (n > LATENCY + 1000) begin
            check({tag, "_done_timeout"}, 32'(n), 32'(LATENCY));
            return;
         end
      end
      check({tag, "_latency"}, 32'(n), 32'(LATENCY));
      tick();
      check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
      check({tag, "_busy_end"},   32'(o_busy), 32'd0);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      fork
         begin
            res_t e;
            forever begin
               @(negedge i_clk);
               if (o_result_valid) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_result", 32'(o_result_idx), 32'hFFFF);
                  end else begin
                     e = exp_q.pop_front();
                     check("res_idx",  32'(o_result_idx),  32'(e.idx));
                     check("res_dx",   32'(o_result_dx),   32'(e.dx));
                     check("res_dy",   32'(o_result_dy),   32'(e.dy));
                     check("res_cost", 32'(o_result_cost), 32'(e.cost));
                  end
               end
            end
         end
      join_none

      for (int a = 0; a < 4096; a++) mem[a] = rnd128();

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      i_reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      // Reset mid-sweep: outputs drop asynchronously
      start_sweep(0, 3);
      repeat (1000) begin
         tick();
         i_start = 1'b0;
      end
      check("abort_busy", 32'(o_busy), 32'd1);
      i_reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      repeat (2) tick();
      i_reset = 1'b0;
      tick();

      // curr==prev everywhere; overrun injected, locations altered mid-sweep
      for (int s = 0; s < 16; s++) begin
         fill_equal(s, 0, 3);
         push_exp(s, 4'd0, 4'd0, 12'd0);
      end
      start_sweep(0, 3);
      run_to_done(1, "equal");
      check("hold_idx", 32'(o_result_idx), 32'd15);

      // Mixed sub-images: shifted, all-zero tie, all-ones vs zeros
      for (int s = 0; s < 16; s++) begin
         if (s == 5) begin
            fill_shift(s, 2, 1);
            push_exp(s, 4'd3, 4'hE, 12'd0);
         end else if (s == 2 || s == 10) begin
            fill_const(s, 2, 1, '0, '0);
            push_exp(s, 4'd0, 4'd0, 12'd0);
         end else if (s == 7 || s == 12) begin
            fill_const(s, 2, 1, '1, '0);
            push_exp(s, 4'd0, 4'd0, 12'd3584);
         end else begin
            fill_equal(s, 2, 1);
            push_exp(s, 4'd0, 4'd0, 12'd0);
         end
      end
      start_sweep(2, 1);
      run_to_done(2, "mixed");
      check("hold_cost", 32'(o_result_cost), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
